// File: rtl/lcrc_checker_if.sv
// Byte-stream, forwarded-stream and frame-result signals of the LCRC checker.
// The master drives the received link bytes; the slave is the checker.
interface lcrc_checker_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_sop;
  logic        in_eop;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        res_valid;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;
  logic        abort;
  logic [11:0] rx_seq;

  modport master (
    output in_valid, in_data, in_sop, in_eop,
    input  out_valid, out_data, out_sop, out_eop,
    input  res_valid, crc_ok, crc_err, len_err, abort, rx_seq
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop,
    output out_valid, out_data, out_sop, out_eop,
    output res_valid, crc_ok, crc_err, len_err, abort, rx_seq
  );
endinterface

// File: rtl/lcrc_checker.sv
// Receive-side LCRC checker: strips the 4 trailing LCRC bytes, forwards the
// rest and reports per-frame good/bad status with the 12-bit sequence number.
//
// state  | meaning
// IDLE   | between frames, waiting for in_sop
// ACTIVE | inside a frame, bytes flowing through the 4-deep hold line
module lcrc_checker #(
  parameter int MIN_BYTES = 7,
  parameter int MAX_BYTES = 4110
) (
  input logic         clk,
  input logic         reset,
  lcrc_checker_if.slave bus
);
  localparam int CW = $clog2(MAX_BYTES + 2);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_BYTES);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BYTES);
  localparam logic [CW-1:0] SAT_C = CW'(MAX_BYTES + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t          state, state_n;
  logic [3:0][7:0] hold, hold_n;
  logic [2:0]      hold_cnt, hold_cnt_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [31:0]     crc, crc_n;
  logic [1:0]      rel_cnt, rel_cnt_n;
  logic [3:0]      seq0, seq0_n;
  logic [7:0]      seq1, seq1_n;

  logic        ov_q, ov_n, osop_q, osop_n, oeop_q, oeop_n;
  logic [7:0]  od_q, od_n;
  logic        rv_q, rv_n, ok_q, ok_n, err_q, err_n, lerr_q, lerr_n, ab_q, ab_n;
  logic [11:0] seq_q, seq_n;
  logic        rel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold     <= '0;
      hold_cnt <= '0;
      cnt      <= '0;
      crc      <= '1;
      rel_cnt  <= '0;
      seq0     <= '0;
      seq1     <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      osop_q   <= 1'b0;
      oeop_q   <= 1'b0;
      rv_q     <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      lerr_q   <= 1'b0;
      ab_q     <= 1'b0;
      seq_q    <= '0;
    end else begin
      state    <= state_n;
      hold     <= hold_n;
      hold_cnt <= hold_cnt_n;
      cnt      <= cnt_n;
      crc      <= crc_n;
      rel_cnt  <= rel_cnt_n;
      seq0     <= seq0_n;
      seq1     <= seq1_n;
      ov_q     <= ov_n;
      od_q     <= od_n;
      osop_q   <= osop_n;
      oeop_q   <= oeop_n;
      rv_q     <= rv_n;
      ok_q     <= ok_n;
      err_q    <= err_n;
      lerr_q   <= lerr_n;
      ab_q     <= ab_n;
      seq_q    <= seq_n;
    end
  end

  always_comb begin
    state_n    = state;
    hold_n     = hold;
    hold_cnt_n = hold_cnt;
    cnt_n      = cnt;
    crc_n      = crc;
    rel_cnt_n  = rel_cnt;
    seq0_n     = seq0;
    seq1_n     = seq1;
    ov_n       = 1'b0;
    od_n       = '0;
    osop_n     = 1'b0;
    oeop_n     = 1'b0;
    rv_n       = 1'b0;
    ok_n       = 1'b0;
    err_n      = 1'b0;
    lerr_n     = 1'b0;
    ab_n       = 1'b0;
    seq_n      = '0;
    rel        = 1'b0;

    case (state)
      IDLE: begin
        if (bus.in_valid && bus.in_sop) begin
          if (bus.in_eop) begin
            rv_n   = 1'b1;
            err_n  = 1'b1;
            lerr_n = 1'b1;
          end else begin
            state_n    = ACTIVE;
            hold_n     = {24'h0, bus.in_data};
            hold_cnt_n = 3'd1;
            cnt_n      = CW'(1);
          end
        end
      end
      ACTIVE: begin
        if (bus.in_valid && bus.in_sop) begin
          // Abort: report the old frame, the new byte opens the next one.
          rv_n       = 1'b1;
          err_n      = 1'b1;
          ab_n       = 1'b1;
          seq_n      = {seq0, seq1};
          hold_n     = {24'h0, bus.in_data};
          hold_cnt_n = 3'd1;
          cnt_n      = CW'(1);
          crc_n      = '1;
          rel_cnt_n  = '0;
          seq0_n     = '0;
          seq1_n     = '0;
          if (bus.in_eop) begin
            state_n    = IDLE;
            hold_n     = '0;
            hold_cnt_n = '0;
            cnt_n      = '0;
          end
        end else if (bus.in_valid) begin
          cnt_n = (cnt == SAT_C) ? cnt : cnt + CW'(1);
          if (hold_cnt == 3'd4) begin
            rel    = 1'b1;
            hold_n = {bus.in_data, hold[3:1]};
            crc_n  = crc_byte(crc, hold[0]);
            ov_n   = 1'b1;
            od_n   = hold[0];
            osop_n = (rel_cnt == 2'd0);
            if (rel_cnt == 2'd0) seq0_n = hold[0][3:0];
            if (rel_cnt == 2'd1) seq1_n = hold[0];
            if (rel_cnt != 2'd2) rel_cnt_n = rel_cnt + 2'd1;
          end else begin
            hold_n[hold_cnt[1:0]] = bus.in_data;
            hold_cnt_n            = hold_cnt + 3'd1;
          end
          if (bus.in_eop) begin
            // The four bytes left in the hold line are the LCRC, LSB first.
            oeop_n     = rel;
            rv_n       = 1'b1;
            lerr_n     = (cnt_n < MIN_C) || (cnt_n > MAX_C);
            ok_n       = !lerr_n && (~crc_n == hold_n);
            err_n      = !ok_n;
            seq_n      = {seq0_n, seq1_n};
            state_n    = IDLE;
            hold_n     = '0;
            hold_cnt_n = '0;
            cnt_n      = '0;
            crc_n      = '1;
            rel_cnt_n  = '0;
            seq0_n     = '0;
            seq1_n     = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_sop   = osop_q;
  assign bus.out_eop   = oeop_q;
  assign bus.res_valid = rv_q;
  assign bus.crc_ok    = ok_q;
  assign bus.crc_err   = err_q;
  assign bus.len_err   = lerr_q;
  assign bus.abort     = ab_q;
  assign bus.rx_seq    = seq_q;
endmodule

// File: tb/tb_lcrc_checker.sv
// Directed bench for lcrc_checker: good, corrupted, gapped, runt, aborted and
// reset-interrupted frames, with forwarded bytes and results logged by a monitor.
module tb_lcrc_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  lcrc_checker_if bus ();

  lcrc_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // {sop, eop, data} per forwarded byte; {ok, err, len, abort, seq} per result
  logic [9:0]  out_q[$];
  logic [15:0] res_q[$];
  logic        stray = 1'b0;

  always @(negedge clk) begin
    if (bus.out_valid) out_q.push_back({bus.out_sop, bus.out_eop, bus.out_data});
    if (bus.res_valid)
      res_q.push_back({bus.crc_ok, bus.crc_err, bus.len_err, bus.abort, bus.rx_seq});
    else if ({bus.crc_ok, bus.crc_err, bus.len_err, bus.abort, bus.rx_seq} != 16'h0)
      stray = 1'b1;
    if (!bus.out_valid && ({bus.out_sop, bus.out_eop} != 2'b00)) stray = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic e);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sop   = s;
    bus.in_eop   = e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[13], input logic gapped);
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, f[i], i == 0, i == 12);
      if (gapped && i != 12) begin
        drive(1'b0, 8'hEE, 1'b0, 1'b0);
        chk("gap_no_out", {31'h0, bus.out_valid}, 32'h0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp[13], input int n,
                           input logic has_eop);
    logic [9:0] obs;
    for (int i = 0; i < n; i++) begin
      obs = (out_q.size() != 0) ? out_q.pop_front() : 10'bx;
      chk(tag, {22'h0, obs}, {22'h0, (i == 0), (has_eop && i == n - 1), exp[i]});
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = (res_q.size() != 0) ? res_q.pop_front() : 16'bx;
    chk(tag, {16'h0, obs}, {16'h0, exp});
  endtask

  logic [7:0] good[13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                           8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
  logic [7:0] bad[13];
  logic [7:0] abf[13] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00,
                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    bad = good;
    bad[12] = 8'hCA;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop,
                          bus.res_valid, bus.crc_ok, bus.crc_err, bus.len_err,
                          bus.abort, bus.rx_seq}, 32'h0);
    reset = 1'b0;
    idle(2);

    // Good frame immediately followed by the corrupted one, no bubble.
    send_frame(good, 1'b0);
    chk("good_res_latency", {31'h0, bus.res_valid}, 32'h1);
    send_frame(bad, 1'b0);
    idle(3);
    chk("b2b_out_count", 32'(out_q.size()), 32'd18);
    check_out("good_bytes", good, 9, 1'b1);
    check_out("bad_bytes", good, 9, 1'b1);
    check_res("good_res", 16'h8132);
    check_res("bad_res", 16'h4132);

    send_frame(good, 1'b1);
    idle(3);
    chk("gapped_out_count", 32'(out_q.size()), 32'd9);
    check_out("gapped_bytes", good, 9, 1'b1);
    check_res("gapped_res", 16'h8132);

    drive(1'b1, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    drive(1'b1, 8'hAB, 1'b0, 1'b1);
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    idle(3);
    chk("runt_no_out", 32'(out_q.size()), 32'd0);
    check_res("runt4_res", 16'h6000);
    check_res("runt1_res", 16'h6000);

    for (int i = 0; i < 6; i++) drive(1'b1, abf[i], i == 0, 1'b0);
    send_frame(good, 1'b0);
    idle(3);
    chk("abort_out_count", 32'(out_q.size()), 32'd11);
    check_out("abort_bytes", abf, 2, 1'b0);
    check_out("after_abort_bytes", good, 9, 1'b1);
    check_res("abort_res", 16'h5011);
    check_res("after_abort_res", 16'h8132);

    drive(1'b1, 8'h31, 1'b1, 1'b0);
    drive(1'b1, 8'h32, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_outputs", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop,
                             bus.res_valid, bus.crc_ok, bus.crc_err, bus.len_err,
                             bus.abort, bus.rx_seq}, 32'h0);
    reset = 1'b0;
    idle(1);
    chk("midreset_no_res", 32'(res_q.size()), 32'd0);
    send_frame(good, 1'b0);
    idle(3);
    chk("post_reset_out_count", 32'(out_q.size()), 32'd9);
    check_out("post_reset_bytes", good, 9, 1'b1);
    check_res("post_reset_res", 16'h8132);
    chk("no_extra_res", 32'(res_q.size()), 32'd0);
    chk("no_stray_flags", {31'h0, stray}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
